// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared widths, ALU op-codes and FSM states for the ALU arbiter
package alu_arb_pkg;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CTRL_W  = 4;
  localparam int DEF_SHAMT_W = 5;
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRLV = 4'd4;
  localparam logic [3:0] ALU_LUI  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_BGEZ = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd12;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/alu_arb_rr2.sv
// alu_arb_rr2: 2-way grant; a lone valid wins, on contention ptr_i picks the winner
module alu_arb_rr2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);
  assign gnt_o[0] = valid_i[0] & (~valid_i[1] | ~ptr_i);
  assign gnt_o[1] = valid_i[1] & (~valid_i[0] | ptr_i);
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters (IDLE/EXEC/RESP)
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every contention (bring-up only).
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [DATA_W-1:0]  req0_src1_i,
  input  logic [DATA_W-1:0]  req0_src2_i,
  input  logic [CTRL_W-1:0]  req0_ctrl_i,
  input  logic [SHAMT_W-1:0] req0_shamt_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [DATA_W-1:0]  req1_src1_i,
  input  logic [DATA_W-1:0]  req1_src2_i,
  input  logic [CTRL_W-1:0]  req1_ctrl_i,
  input  logic [SHAMT_W-1:0] req1_shamt_i,
  output logic               rsp0_valid_o,
  input  logic               rsp0_ready_i,
  output logic [DATA_W-1:0]  rsp0_result_o,
  output logic               rsp0_zero_o,
  output logic               rsp1_valid_o,
  input  logic               rsp1_ready_i,
  output logic [DATA_W-1:0]  rsp1_result_o,
  output logic               rsp1_zero_o,
  output logic [DATA_W-1:0]  alu_src1_o,
  output logic [DATA_W-1:0]  alu_src2_o,
  output logic [CTRL_W-1:0]  alu_ctrl_o,
  output logic [SHAMT_W-1:0] alu_shamt_o,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic               alu_zero_i,
  output logic               busy_o,
  output logic               grant_id_o
);
  state_e              r_state;
  logic                r_gid;
  logic [DATA_W-1:0]   r_src1, r_src2, r_res0, r_res1;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [SHAMT_W-1:0]  r_shamt;
  logic [1:0]          r_rsp_valid, r_rsp_zero;
  logic [1:0]          w_gnt;
  logic                w_ptr, w_idle, w_acc, w_done;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_ptr = 1'b0;
`else
  logic r_rr_ptr;
  // hand contention priority to the requester not just served
  always_ff @(posedge clk_i)
    if (rst_i) r_rr_ptr <= 1'b0;
    else if (w_done) r_rr_ptr <= ~r_gid;
  assign w_ptr = r_rr_ptr;
`endif
  alu_arb_rr2 u_rr2 (
    .valid_i({req1_valid_i, req0_valid_i}),
    .ptr_i  (w_ptr),
    .gnt_o  (w_gnt)
  );
  assign w_idle       = r_state == IDLE;
  assign req0_ready_o = w_idle & w_gnt[0];
  assign req1_ready_o = w_idle & w_gnt[1];
  assign w_acc        = w_idle & |w_gnt;
  assign w_done       = (r_state == RESP) & (r_gid ? rsp1_ready_i : rsp0_ready_i);
  // sequencing: accept -> one ALU evaluation cycle -> hold response until consumed
  always_ff @(posedge clk_i)
    if (rst_i) r_state <= IDLE;
    else if (w_acc) r_state <= EXEC;
    else if (r_state == EXEC) r_state <= RESP;
    else if (w_done) r_state <= IDLE;
  // latch the winner's operands; they stay put until the next grant
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_src1  <= '0;
      r_src2  <= '0;
      r_ctrl  <= '0;
      r_shamt <= '0;
      r_gid   <= 1'b0;
    end else if (w_acc) begin
      r_src1  <= w_gnt[1] ? req1_src1_i : req0_src1_i;
      r_src2  <= w_gnt[1] ? req1_src2_i : req0_src2_i;
      r_ctrl  <= w_gnt[1] ? req1_ctrl_i : req0_ctrl_i;
      r_shamt <= w_gnt[1] ? req1_shamt_i : req0_shamt_i;
      r_gid   <= w_gnt[1];
    end
  // capture the ALU output into the granted requester's response slot only
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_rsp_valid <= '0;
      r_rsp_zero  <= '0;
      r_res0      <= '0;
      r_res1      <= '0;
    end else if (r_state == EXEC) begin
      r_rsp_valid[r_gid] <= 1'b1;
      r_rsp_zero[r_gid]  <= alu_zero_i;
      if (r_gid) r_res1 <= alu_result_i;
      else r_res0 <= alu_result_i;
    end else if (w_done) r_rsp_valid[r_gid] <= 1'b0;
  assign alu_src1_o    = r_src1;
  assign alu_src2_o    = r_src2;
  assign alu_ctrl_o    = r_ctrl;
  assign alu_shamt_o   = r_shamt;
  assign rsp0_valid_o  = r_rsp_valid[0];
  assign rsp1_valid_o  = r_rsp_valid[1];
  assign rsp0_zero_o   = r_rsp_zero[0];
  assign rsp1_zero_o   = r_rsp_zero[1];
  assign rsp0_result_o = r_res0;
  assign rsp1_result_o = r_res1;
  assign busy_o        = ~w_idle;
  assign grant_id_o    = r_gid;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed table, corner sequences and random traffic against a transaction model
module tb_alu_share_arb;
  import alu_arb_pkg::*;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  v = 2'b00, rsp_rdy = 2'b00;
  logic [31:0] s1 [2], s2 [2];
  logic [3:0]  c [2];
  logic [4:0]  sh [2];
  logic [1:0]  rdy, rv, rz;
  logic [31:0] res [2];
  logic [31:0] a1, a2, alu_res;
  logic [3:0]  ac;
  logic [4:0]  ash;
  logic        alu_z, busy, gid;
  int n_chk = 0, n_pass = 0;
  logic [31:0] last_res [2];

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, b, input logic [3:0] op, input logic [4:0] s);
    case (op)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_ADD:  return a + b;
      ALU_SRL:  return b >> s;
      ALU_SRLV: return b >> a[4:0];
      ALU_LUI:  return {b[15:0], 16'h0};
      ALU_SUB:  return a - b;
      ALU_SLT:  return {31'h0, $signed(a) < $signed(b)};
      ALU_BGEZ: return {31'h0, ~a[31]};
      ALU_MUL:  return a * b;
      ALU_NOR:  return ~(a | b);
      default:  return 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_res = alu_fn(a1, a2, ac, ash);
    alu_z   = alu_res == 32'h0;
  end

  alu_share_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(v[0]), .req0_ready_o(rdy[0]), .req0_src1_i(s1[0]), .req0_src2_i(s2[0]),
    .req0_ctrl_i(c[0]), .req0_shamt_i(sh[0]),
    .req1_valid_i(v[1]), .req1_ready_o(rdy[1]), .req1_src1_i(s1[1]), .req1_src2_i(s2[1]),
    .req1_ctrl_i(c[1]), .req1_shamt_i(sh[1]),
    .rsp0_valid_o(rv[0]), .rsp0_ready_i(rsp_rdy[0]), .rsp0_result_o(res[0]), .rsp0_zero_o(rz[0]),
    .rsp1_valid_o(rv[1]), .rsp1_ready_i(rsp_rdy[1]), .rsp1_result_o(res[1]), .rsp1_zero_o(rz[1]),
    .alu_src1_o(a1), .alu_src2_o(a2), .alu_ctrl_o(ac), .alu_shamt_o(ash),
    .alu_result_i(alu_res), .alu_zero_i(alu_z),
    .busy_o(busy), .grant_id_o(gid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int id, input logic vv, input logic [31:0] x, y, input logic [3:0] cc, input logic [4:0] ss);
    v[id]  = vv;
    s1[id] = x;
    s2[id] = y;
    c[id]  = cc;
    sh[id] = ss;
  endtask

  typedef struct {
    int          id;
    logic [31:0] x, y;
    logic [3:0]  cc;
    logic [4:0]  ss;
    logic [31:0] er;
    logic        ez;
  } vec_t;

  task automatic run_single(input vec_t t);
    int o = 1 - t.id;
    set_req(t.id, 1'b1, t.x, t.y, t.cc, t.ss);
    #1;
    chk("single_ready", 32'(rdy), 32'd1 << t.id);
    step();
    v[t.id] = 1'b0;
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_grant_id", 32'(gid), 32'(t.id));
    chk("single_alu_src1", a1, t.x);
    chk("single_alu_src2", a2, t.y);
    chk("single_alu_ctrl", 32'(ac), 32'(t.cc));
    chk("single_alu_shamt", 32'(ash), 32'(t.ss));
    chk("single_rsp_early", 32'(rv), 32'd0);
    step();
    chk("single_rsp_valid", 32'(rv), 32'd1 << t.id);
    chk("single_result", res[t.id], t.er);
    chk("single_zero", 32'(rz[t.id]), 32'(t.ez));
    chk("single_other_result", res[o], last_res[o]);
    step();
    chk("single_rsp_done", 32'(rv), 32'd0);
    chk("single_idle", 32'(busy), 32'd0);
    last_res[t.id] = t.er;
  endtask

  initial begin
    vec_t tbl [12];
    int   ord [3];
    bit   m_busy;
    int   m_g, age, m_prio, nw;
    logic [31:0] m_res, nres;
    logic [1:0]  exp_rdy;
    bit   acc, done;
    tbl[0]  = '{0, 32'h5,        32'h7,        ALU_ADD,  5'd0, 32'hC,        1'b0};
    tbl[1]  = '{1, 32'h9,        32'h9,        ALU_SUB,  5'd0, 32'h0,        1'b1};
    tbl[2]  = '{0, 32'hF0,       32'h0F,       ALU_OR,   5'd0, 32'hFF,       1'b0};
    tbl[3]  = '{1, 32'hFF00,     32'h0FF0,     ALU_AND,  5'd0, 32'hF00,      1'b0};
    tbl[4]  = '{0, 32'h0,        32'h80,       ALU_SRL,  5'd3, 32'h10,       1'b0};
    tbl[5]  = '{1, 32'h0,        32'h1234,     ALU_LUI,  5'd0, 32'h12340000, 1'b0};
    tbl[6]  = '{0, 32'h0,        32'h0,        ALU_NOR,  5'd0, 32'hFFFFFFFF, 1'b0};
    tbl[7]  = '{1, 32'h3,        32'h4,        4'd10,    5'd0, 32'h0,        1'b1};
    tbl[8]  = '{0, 32'hFFFFFFFF, 32'h1,        ALU_SLT,  5'd0, 32'h1,        1'b0};
    tbl[9]  = '{1, 32'h6,        32'h7,        ALU_MUL,  5'd0, 32'h2A,       1'b0};
    tbl[10] = '{0, 32'hABC,      32'hDEF,      4'd15,    5'd9, 32'h0,        1'b1};
    tbl[11] = '{1, 32'h4,        32'h100,      ALU_SRLV, 5'd0, 32'h10,       1'b0};
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, 32'h0, 32'h0, 4'h0, 5'h0);
      last_res[i] = 32'h0;
    end
    // reset then idle
    step();
    step();
    rst_i = 1'b0;
    chk("reset_ready", 32'(rdy), 32'd0);
    chk("reset_rsp_valid", 32'(rv), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant_id", 32'(gid), 32'd0);
    chk("reset_alu_src1", a1, 32'd0);
    chk("reset_alu_src2", a2, 32'd0);
    chk("reset_alu_ctrl_shamt", {23'h0, ac, ash}, 32'd0);
    chk("reset_rsp_result0", res[0], 32'd0);
    chk("reset_rsp_result1", res[1], 32'd0);
    chk("reset_rsp_zero", 32'(rz), 32'd0);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    // directed single ops, alternating requesters, response always ready
    rsp_rdy = 2'b11;
    for (int i = 0; i < 12; i++) run_single(tbl[i]);
    // contention: both valid continuously
`ifdef ALU_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 0};
`else
    ord = '{0, 1, 0};
`endif
    set_req(0, 1'b1, 32'h9, 32'h9, ALU_SUB, 5'd0);
    set_req(1, 1'b1, 32'hF0, 32'h0F, ALU_OR, 5'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("contend_ready", 32'(rdy), 32'd1 << ord[k]);
      step();
      chk("contend_grant_id", 32'(gid), 32'(ord[k]));
      step();
      chk("contend_rsp_valid", 32'(rv), 32'd1 << ord[k]);
      chk("contend_result", res[ord[k]], ord[k] == 1 ? 32'hFF : 32'h0);
      chk("contend_zero", 32'(rz[ord[k]]), ord[k] == 1 ? 32'd0 : 32'd1);
      step();
    end
    v = 2'b00;
    // response backpressure on requester 1 while requester 0 waits
    rsp_rdy = 2'b00;
    set_req(1, 1'b1, 32'h3, 32'h4, ALU_ADD, 5'd0);
    #1;
    chk("bp_req1_ready", 32'(rdy), 32'b10);
    step();
    v[1] = 1'b0;
    set_req(0, 1'b1, 32'h1, 32'h1, ALU_ADD, 5'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp1_held", 32'(rv), 32'b10);
      chk("bp_result_held", res[1], 32'h7);
      chk("bp_req0_blocked", 32'(rdy), 32'd0);
      step();
    end
    rsp_rdy = 2'b11;
    #1;
    chk("bp_req0_blocked_at_hs", 32'(rdy), 32'd0);
    step();
    chk("bp_rsp1_released", 32'(rv), 32'd0);
    chk("bp_req0_ready", 32'(rdy), 32'b01);
    step();
    v[0] = 1'b0;
    chk("bp_req0_granted", {30'h0, busy, gid}, 32'b10);
    step();
    chk("bp_req0_result", res[0], 32'h2);
    step();
    // reset mid-operation discards the op and clears the round-robin pointer
    set_req(0, 1'b1, 32'h8, 32'h8, ALU_ADD, 5'd0);
    #1;
    chk("rst_mid_ready", 32'(rdy), 32'b01);
    step();
    v[0] = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_alu_src1", a1, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_no_rsp", 32'(rv), 32'd0);
      step();
    end
    set_req(0, 1'b1, 32'h1, 32'h2, ALU_ADD, 5'd0);
    set_req(1, 1'b1, 32'h1, 32'h2, ALU_ADD, 5'd0);
    #1;
    chk("rst_mid_rr_ptr0", 32'(rdy), 32'b01);
    step();
    v = 2'b00;
    step();
    step();
    // random traffic against a transaction-level model
    m_busy = 1'b0;
    m_g = 0;
    age = 0;
    m_res = 32'h0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    m_prio = 0;
`else
    m_prio = 1;
`endif
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
          else
            set_req(i, 1'b1, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 3)));
        end else if (v[i] && $urandom_range(0, 9) == 0) v[i] = 1'b0;
      end
      rsp_rdy = 2'($urandom_range(0, 3));
      #1;
      if (m_busy || v == 2'b00) exp_rdy = 2'b00;
      else if (v != 2'b11) exp_rdy = v;
      else exp_rdy = (m_prio == 1) ? 2'b10 : 2'b01;
      chk("rand_ready", 32'(rdy), 32'(exp_rdy));
      chk("rand_rsp_valid", 32'(rv), (m_busy && age >= 1) ? 32'd1 << m_g : 32'd0);
      if (m_busy && age >= 1) begin
        chk("rand_result", res[m_g], m_res);
        chk("rand_zero", 32'(rz[m_g]), 32'(m_res == 32'h0));
      end
      acc  = exp_rdy != 2'b00;
      done = m_busy && age >= 1 && rsp_rdy[m_g];
      nw   = exp_rdy[1] ? 1 : 0;
      nres = alu_fn(s1[nw], s2[nw], c[nw], sh[nw]);
      step();
      if (acc) begin
        m_busy = 1'b1;
        m_g = nw;
        age = 0;
        m_res = nres;
        v[nw] = 1'b0;
      end else if (done) begin
        m_busy = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        m_prio = 0;
`else
        m_prio = 1 - m_g;
`endif
      end else if (m_busy) age++;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single-cycle combinational ALU (32-bit, 4-bit ctrl, 5-bit shamt) between two requesters, e.g. the main datapath and a branch/address unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- A 3-state FSM does the sequencing:
  - grant one requester;
  - register its operands onto the ALU inputs;
  - capture the ALU result and zero flag;
  - hold them until the response is accepted.
- Round-robin fairness by default.

Parameters:
- DATA_W, 32, operand/result width
- CTRL_W, 4, ALU op-code width
- SHAMT_W, 5, shift-amount width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- req{0,1}_valid_i  in  1  request valid
- req{0,1}_ready_o  out  1  request accepted this cycle
- req{0,1}_src1_i  in  DATA_W  operand 1
- req{0,1}_src2_i  in  DATA_W  operand 2
- req{0,1}_ctrl_i  in  CTRL_W  ALU op
- req{0,1}_shamt_i  in  SHAMT_W  shift amount
- rsp{0,1}_valid_o  out  1  response valid
- rsp{0,1}_ready_i  in  1  response consumed
- rsp{0,1}_result_o  out  DATA_W  captured ALU result
- rsp{0,1}_zero_o  out  1  captured ALU zero flag
- alu_src1_o  out  DATA_W  to ALU src1
- alu_src2_o  out  DATA_W  to ALU src2
- alu_ctrl_o  out  CTRL_W  to ALU ctrl
- alu_shamt_o  out  SHAMT_W  to ALU shamt
- alu_result_i  in  DATA_W  from ALU result
- alu_zero_i  in  1  from ALU zero
- busy_o  out  1  high in EXEC or RESP
- grant_id_o  out  1  requester currently owning the ALU

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0
  - op registers (alu_*_o)=0
  - rsp*_valid_o=0, rsp*_result_o=0, rsp*_zero_o=0
  - busy_o=0, grant_id_o=0
- Reset mid-operation: the in-flight op is discarded and no response is issued.
- States:
  - IDLE: grant selection is combinational.
    - Exactly one req valid -> that requester wins.
    - Both valid -> requester rr_ptr wins.
    - reqN_ready_o=1 only for the winner, only in IDLE.
    - On the handshake: latch src1/src2/ctrl/shamt into the op registers, set grant_id_o, go EXEC.
  - EXEC: the ALU evaluates the registered operands. At the clock edge: capture alu_result_i/alu_zero_i into rspG_result_o/rspG_zero_o, set rspG_valid_o=1, go RESP.
  - RESP: hold rspG_valid_o, result and zero stable until rspG_ready_i=1. On that handshake: rspG_valid_o=0, rr_ptr=~grant_id_o, go IDLE.
- Latency and throughput:
  - Request accepted at edge N -> rsp valid from edge N+2.
  - rsp_ready held high -> next grant at edge N+3 earliest.
  - Throughput: one op per 3 cycles.
- Operand and response holding:
  - The op registers hold their last value in IDLE; the ALU inputs never glitch during EXEC/RESP.
  - The non-granted requester's response registers are untouched.
- Requester obligations: hold valid and operands stable until ready; a requester may drop valid before grant without side effect.
- Ctrl values:
  - Passed unmodified, no decode.
  - Undefined codes (10, 11, 13-15) still complete; the ALU returns 0, so rsp_zero_o=1.
- rr_ptr updates only on the response handshake, never on grant.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined:
  - requester 0 wins every IDLE contention;
  - rr_ptr is removed, or tied to 0.
  - Requester 1 can starve; this is intended for bring-up only.
- Undefined: round-robin as specified above.

Decomposition:
- Package alu_arb_pkg holds:
  - ALU op-code localparams: AND=0, OR=1, ADD=2, SRL=3, SRLV=4, LUI=5, SUB=6, SLT=7, BGEZ=8, MUL=9, NOR=12.
  - FSM state enum: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - DATA_W/CTRL_W/SHAMT_W defaults.
- One sub-module is natural: alu_arb_rr2, the 2-way grant logic (valids, rr_ptr -> one-hot grant). It is shared with future arbiters.
- The ALU itself is instantiated outside; this block only drives and samples its ports.

Test Plan:
- Reset then idle: rst_i high 2 cycles, no valids -> all outputs 0, busy_o=0, both ready_o=0.
- Single op, req0 ADD: src1=5, src2=7, ctrl=2 -> req0_ready_o in IDLE; alu_src1_o=5 next cycle; rsp0_valid_o=1 at N+2 with result=12, zero=0; rsp1_valid_o stays 0.
- Contention and round-robin:
  - Both valid continuously: req0 SUB 9-9 (ctrl=6), req1 OR 0xF0|0x0F (ctrl=1), rsp ready always 1.
  - Required order: req0 first (result 0, zero=1), then req1 (0xFF), then req0 again.
- Response backpressure: rsp1_ready_i low for 5 cycles -> rsp1_valid_o and result held stable; req0 pending gets no ready until the rsp1 handshake; then req0 is granted next cycle.
- Reset mid-op: assert rst_i in EXEC -> next cycle state IDLE, no rsp valid ever issued for that op, rr_ptr=0.
- ALU_ARB_FIXED_PRIO_EN defined, both valid continuously -> req0 granted on every IDLE, req1 never granted.
